// File: rtl/vx_ti_mem_pkg.sv
// Shared types and constants for the T&I memory responder.
// Contents:
//   TI_MEM_*_WIDTH     default bus widths that size the structs below
//   TI_MEM_WORD_BYTES  bytes per store word, which is also the byteen width
//   TI_MEM_IDX_BITS    word index width for the default store depth
//   ti_mem_req_t       one request beat {rw, addr, byteen, data, tag}
//   ti_mem_rsp_t       one response entry {data, tag, err}
//   ti_mem_meta_t      read pipeline sideband {valid, tag, err}
//   ti_mem_merge()     byte-lane merge used for masked writes
package vx_ti_mem_pkg;

  localparam int TI_MEM_DATA_WIDTH = 32;
  localparam int TI_MEM_ADDR_WIDTH = 32;
  localparam int TI_MEM_TAG_WIDTH  = 8;
  localparam int TI_MEM_MEM_WORDS  = 1024;
  localparam int TI_MEM_WORD_BYTES = TI_MEM_DATA_WIDTH / 8;
  localparam int TI_MEM_IDX_BITS   = $clog2(TI_MEM_MEM_WORDS);

  typedef struct packed {
    logic                         rw;
    logic [TI_MEM_ADDR_WIDTH-1:0] addr;
    logic [TI_MEM_WORD_BYTES-1:0] byteen;
    logic [TI_MEM_DATA_WIDTH-1:0] data;
    logic [TI_MEM_TAG_WIDTH-1:0]  tag;
  } ti_mem_req_t;

  typedef struct packed {
    logic [TI_MEM_DATA_WIDTH-1:0] data;
    logic [TI_MEM_TAG_WIDTH-1:0]  tag;
    logic                         err;
  } ti_mem_rsp_t;

  typedef struct packed {
    logic                        valid;
    logic [TI_MEM_TAG_WIDTH-1:0] tag;
    logic                        err;
  } ti_mem_meta_t;

  // Lanes with a set enable take the new byte; the others keep the old one.
  function automatic logic [TI_MEM_DATA_WIDTH-1:0] ti_mem_merge(
    input logic [TI_MEM_DATA_WIDTH-1:0] old_word,
    input logic [TI_MEM_DATA_WIDTH-1:0] new_word,
    input logic [TI_MEM_WORD_BYTES-1:0] byteen
  );
    logic [TI_MEM_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < TI_MEM_WORD_BYTES; b++) begin
      if (byteen[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_ti_mem_responder_if.sv
// Single-lane LSU memory bus between a requester (master) and the on-chip
// responder (slave).
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// While valid is high and ready is low, the source holds every field of the
// beat stable. A source does not wait for ready before raising valid.
//
// Signals:
//   req_valid/req_ready    request handshake (master -> slave)
//   req_rw                 1 = write, 0 = read
//   req_addr               byte address
//   req_byteen             write byte enables
//   req_data               write data
//   req_tag                request tag, returned with read data
//   rsp_valid/rsp_ready    response handshake (slave -> master)
//   rsp_data/rsp_tag       read data and the tag of its read
//   rsp_err                address out of range or misaligned
interface vx_ti_mem_responder_if;
  import vx_ti_mem_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_rw;
  logic [TI_MEM_ADDR_WIDTH-1:0] req_addr;
  logic [TI_MEM_WORD_BYTES-1:0] req_byteen;
  logic [TI_MEM_DATA_WIDTH-1:0] req_data;
  logic [TI_MEM_TAG_WIDTH-1:0]  req_tag;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [TI_MEM_DATA_WIDTH-1:0] rsp_data;
  logic [TI_MEM_TAG_WIDTH-1:0]  rsp_tag;
  logic                         rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/vx_ti_mem_rsp_fifo.sv
// Synchronous response FIFO for the memory responder.
// The head entry comes straight from storage, so a push into an empty FIFO
// becomes visible on the following cycle (no push-to-pop bypass).
// Ports:
//   clk, reset    clock, synchronous active-high reset (flushes all entries)
//   push_i        write push_data_i at the clock edge (ignored when full)
//   push_data_i   entry to enqueue
//   pop_i         drop the head entry at the clock edge (ignored when empty)
//   head_o        oldest entry; only meaningful while empty_o is low
//   count_o       number of stored entries
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module vx_ti_mem_rsp_fifo
  import vx_ti_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  ti_mem_rsp_t                push_data_i,
  input  logic                       pop_i,
  output ti_mem_rsp_t                head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  ti_mem_rsp_t      buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = buf_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vx_ti_mem_responder.sv
// Responder end of the T&I single-lane memory protocol. Requests are served
// from a word-addressed on-chip store; reads return tagged responses in
// accept order, writes are byte-masked and produce no response.
// Ports:
//   clk      clock
//   reset    synchronous, active-high; flushes read pipeline and response
//            FIFO, leaves store contents intact
//   bus      vx_ti_mem_responder_if.slave (request and response channels)
//   busy_o   reads in the pipeline or responses waiting in the FIFO
// Parameters: DATA/ADDR/TAG_WIDTH must equal the package constants that
// size the bus structs; MEM_WORDS is a power of two; BASE_ADDR is word
// aligned; READ_LATENCY >= 1; RSP_FIFO_DEPTH >= READ_LATENCY.
module vx_ti_mem_responder
  import vx_ti_mem_pkg::*;
#(
  parameter int                           DATA_WIDTH     = TI_MEM_DATA_WIDTH,
  parameter int                           ADDR_WIDTH     = TI_MEM_ADDR_WIDTH,
  parameter int                           TAG_WIDTH      = TI_MEM_TAG_WIDTH,
  parameter int                           MEM_WORDS      = TI_MEM_MEM_WORDS,
  parameter logic [TI_MEM_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                           READ_LATENCY   = 2,
  parameter int                           RSP_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_ti_mem_responder_if.slave  bus,
  output logic                  busy_o
);

  localparam int OFF_BITS    = $clog2(DATA_WIDTH / 8);
  localparam int IDX_BITS    = $clog2(MEM_WORDS);
  localparam int WOFF_W      = ADDR_WIDTH - OFF_BITS;
  // The FIFO write is the final register, so the pipe holds one stage fewer.
  localparam int PIPE_STAGES = READ_LATENCY - 1;
  localparam int CNT_W       = $clog2(RSP_FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  ti_mem_req_t           req;
  logic [ADDR_WIDTH:0]   rel_ext;      // MSB is the borrow of addr - BASE_ADDR
  logic [WOFF_W-1:0]     word_off;
  logic [IDX_BITS-1:0]   idx;
  logic                  misaligned, below_base, out_of_range, req_err;
  logic [TAG_WIDTH-1:0]  req_tag;

  always_comb begin
    req        = '0;
    req.rw     = bus.req_rw;
    req.addr   = bus.req_addr;
    req.byteen = bus.req_byteen;
    req.data   = bus.req_data;
    req.tag    = bus.req_tag;
  end

  assign rel_ext      = {1'b0, req.addr} - {1'b0, BASE_ADDR};
  assign below_base   = rel_ext[ADDR_WIDTH];
  assign misaligned   = |rel_ext[OFF_BITS-1:0];
  assign word_off     = rel_ext[ADDR_WIDTH-1:OFF_BITS];
  assign out_of_range = (word_off >= WOFF_W'(MEM_WORDS));
  assign req_err      = misaligned || below_base || out_of_range;
  assign idx          = word_off[IDX_BITS-1:0];
  assign req_tag      = req.tag;

  // ------------------------------------------------------------- handshake
  logic req_ready, accept, wr_en, rd_accept;
  logic rsp_valid_int, pop;

  assign accept    = bus.req_valid && req_ready;
  assign wr_en     = accept && req.rw && !req_err;
  assign rd_accept = accept && !req.rw;
  assign pop       = rsp_valid_int && bus.rsp_ready;

  // ----------------------------------------------------------------- store
  // Not reset: scene data survives a reset of the request path.
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= ti_mem_merge(mem_q[idx], req.data, req.byteen);
  end

  // Read and write share one issue port, so a read sees every write accepted
  // on an earlier edge.
  assign rd_data = req_err ? '0 : mem_q[idx];

  // ---------------------------------------------------------- read pipeline
  ti_mem_meta_t new_meta;
  logic         exit_valid;
  ti_mem_rsp_t  exit_rsp;
  logic         pipe_busy;

  always_comb begin
    new_meta       = '0;
    new_meta.valid = rd_accept;
    new_meta.tag   = req_tag;
    new_meta.err   = req_err;
  end

  if (PIPE_STAGES > 0) begin : g_pipe
    ti_mem_meta_t          meta_q  [PIPE_STAGES];
    ti_mem_meta_t          meta_d  [PIPE_STAGES];
    logic [DATA_WIDTH-1:0] pdata_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0] pdata_d [PIPE_STAGES];

    // Fixed-length shift: the pipe never stalls because the credit count
    // reserves a FIFO slot for every read in flight.
    always_comb begin
      meta_d     = meta_q;
      pdata_d    = pdata_q;
      meta_d[0]  = new_meta;
      pdata_d[0] = rd_data;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        meta_d[i]  = meta_q[i-1];
        pdata_d[i] = pdata_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_STAGES; i++) meta_q[i] <= '0;
      end else begin
        meta_q <= meta_d;
      end
    end

    always_ff @(posedge clk) begin
      pdata_q <= pdata_d;
    end

    always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < PIPE_STAGES; i++) pipe_busy = pipe_busy | meta_q[i].valid;
    end

    always_comb begin
      exit_rsp      = '0;
      exit_valid    = meta_q[PIPE_STAGES-1].valid;
      exit_rsp.data = pdata_q[PIPE_STAGES-1];
      exit_rsp.tag  = meta_q[PIPE_STAGES-1].tag;
      exit_rsp.err  = meta_q[PIPE_STAGES-1].err;
    end
  end else begin : g_nopipe
    assign pipe_busy = 1'b0;
    always_comb begin
      exit_rsp      = '0;
      exit_valid    = rd_accept;
      exit_rsp.data = rd_data;
      exit_rsp.tag  = req_tag;
      exit_rsp.err  = req_err;
    end
  end

  // ---------------------------------------------------------- response FIFO
  ti_mem_rsp_t      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  vx_ti_mem_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (exit_valid && !fifo_full),
    .push_data_i (exit_rsp),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ---------------------------------------------------------- credit counter
  // inflight = reads in the pipe + FIFO entries. Held in a register so that
  // req_ready depends on no combinational input.
  logic [CNT_W-1:0] inflight_q, inflight_d;

  always_comb begin
    inflight_d = inflight_q;
    case ({rd_accept, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  // ----------------------------------------------------------------- outputs
  assign req_ready     = !reset && (inflight_q < CNT_W'(RSP_FIFO_DEPTH));
  assign rsp_valid_int = !reset && !fifo_empty;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_valid_int ? fifo_head.data : '0;
  assign bus.rsp_tag   = rsp_valid_int ? fifo_head.tag  : '0;
  assign bus.rsp_err   = rsp_valid_int ? fifo_head.err  : 1'b0;
  assign busy_o        = !reset && (pipe_busy || (fifo_count != '0));

endmodule

// File: tb/tb_vx_ti_mem_responder.sv
// Bench for vx_ti_mem_responder: directed scenarios plus a randomized mix,
// with read responses checked against an expected queue fed at accept time.
module tb_vx_ti_mem_responder;
  import vx_ti_mem_pkg::*;

  localparam int W = 1 + 8 + 32;  // {err, tag, data}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  vx_ti_mem_responder_if bus();

  vx_ti_mem_responder #(
    .MEM_WORDS      (1024),
    .BASE_ADDR      (32'h0),
    .READ_LATENCY   (2),
    .RSP_FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy_o (busy)
  );

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [31:0]  model_mem [int];

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  // Scoreboard: every response handshake is compared against the queue head.
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rsp: got err=%b tag=%h data=%h, required no response",
                 bus.rsp_err, bus.rsp_tag, bus.rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.rsp_err, bus.rsp_tag, bus.rsp_data} !== mon_exp)
          $display("FAIL rsp_scoreboard: got err=%b tag=%h data=%h, required err=%b tag=%h data=%h",
                   bus.rsp_err, bus.rsp_tag, bus.rsp_data, mon_exp[40], mon_exp[39:32], mon_exp[31:0]);
        else passes++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Drives one request starting at posedge+1 and returns at posedge+1 after
  // it is accepted. Reads with track=1 push their expected response.
  task automatic send(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] data, input logic [7:0] tag, input bit track,
                      output int waits);
    logic [31:0] old;
    bus.req_valid  = 1'b1;
    bus.req_rw     = rw;
    bus.req_addr   = addr;
    bus.req_byteen = be;
    bus.req_data   = data;
    bus.req_tag    = tag;
    waits = 0;
    @(negedge clk);
    while (!bus.req_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      checks++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, waits);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      return;
    end
    if (rw) begin
      if (!addr_err(addr)) begin
        old = model_mem.exists(int'(addr >> 2)) ? model_mem[int'(addr >> 2)] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = data[8*b +: 8];
        model_mem[int'(addr >> 2)] = old;
      end
    end else if (track) begin
      if (addr_err(addr)) exp_q.push_back({1'b1, tag, 32'h0});
      else                exp_q.push_back({1'b0, tag, model_mem[int'(addr >> 2)]});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b000)
        $display("FAIL reset_ctrl: ready/valid/busy=%b, required 000", {bus.req_ready, bus.rsp_valid, busy});
      else passes++;
      checks++;
      if ({bus.rsp_err, bus.rsp_tag, bus.rsp_data} !== 41'h0)
        $display("FAIL reset_rsp: err/tag/data=%h, required 0", {bus.rsp_err, bus.rsp_tag, bus.rsp_data});
      else passes++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", bus.req_ready);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int w;
    bus.rsp_ready = 1'b1;
    send(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 8'h00, 1'b1, w);
    send(1'b0, 32'h10, 4'h0, 32'h0, 8'h5A, 1'b1, w);
    checks++;
    if (w !== 0) $display("FAIL rd_accept_wait: waited %0d cycles, required 0", w);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL latency_early: rsp_valid=%b at N+1, required 0", bus.rsp_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL latency_n2: rsp_valid=%b at N+2, required 1", bus.rsp_valid);
    else passes++;
    checks++;
    if ({bus.rsp_err, bus.rsp_tag, bus.rsp_data} !== {1'b0, 8'h5A, 32'hDEAD_BEEF})
      $display("FAIL wr_rd_data: err=%b tag=%h data=%h, required 0 5a deadbeef", bus.rsp_err, bus.rsp_tag, bus.rsp_data);
    else passes++;
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_byteen();
    int w;
    bus.rsp_ready = 1'b1;
    send(1'b1, 32'h20, 4'hF, 32'h1122_3344, 8'h00, 1'b1, w);
    send(1'b1, 32'h20, 4'h5, 32'hAABB_CCDD, 8'h00, 1'b1, w);
    send(1'b0, 32'h20, 4'h0, 32'h0, 8'h3C, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h11BB_33DD)
      $display("FAIL byteen_merge: valid=%b data=%h, required 1 11bb33dd", bus.rsp_valid, bus.rsp_data);
    else passes++;
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_throughput();
    int w;
    int total = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, (i % 2 == 0) ? 32'h10 : 32'h20, 4'h0, 32'h0, 8'(8'h80 + i), 1'b1, w);
      total += w;
    end
    checks++;
    if (total !== 0) $display("FAIL throughput: %0d stall cycles over 8 reads, required 0", total);
    else passes++;
    wait_drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_rw     = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_byteen = 4'h0;
    bus.req_data   = 32'h0;
    bus.req_tag    = 8'h00;
    while (n < 10 && acc < 6) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back({1'b0, 8'(acc), model_mem[4]});
        @(posedge clk); #1;
        acc++;
        bus.req_tag = 8'(acc);
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    checks++;
    if (acc !== 4) $display("FAIL bp_accepted: %0d reads accepted, required 4", acc);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_credit: req_ready=%b busy=%b, required 0 1", bus.req_ready, busy);
    else passes++;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (acc < 6 && n < 50) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back({1'b0, 8'(acc), model_mem[4]});
        @(posedge clk); #1;
        acc++;
        bus.req_tag = 8'(acc);
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (acc !== 6) $display("FAIL bp_remaining: %0d reads accepted, required 6", acc);
    else passes++;
    wait_drain();
  endtask

  task automatic test_errors();
    int w;
    bus.rsp_ready = 1'b1;
    send(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 8'h00, 1'b1, w);
    send(1'b0, 32'h1002, 4'h0, 32'h0, 8'h21, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tag, bus.rsp_data} !== {1'b1, 1'b1, 8'h21, 32'h0})
      $display("FAIL err_misaligned: valid=%b err=%b tag=%h data=%h, required 1 1 21 00000000",
               bus.rsp_valid, bus.rsp_err, bus.rsp_tag, bus.rsp_data);
    else passes++;
    @(posedge clk); #1;
    send(1'b0, 32'h1000, 4'h0, 32'h0, 8'h22, 1'b1, w);
    send(1'b0, 32'h12, 4'h0, 32'h0, 8'h23, 1'b1, w);
    send(1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 8'h25, 1'b1, w);
    send(1'b1, 32'h1000, 4'hF, 32'h0BAD_BAD0, 8'h00, 1'b1, w);
    send(1'b1, 32'h2, 4'hF, 32'h0BAD_BAD0, 8'h00, 1'b1, w);
    send(1'b0, 32'h0, 4'h0, 32'h0, 8'h24, 1'b1, w);
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    int w;
    int seen = 0;
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h10, 4'h0, 32'h0, 8'h61, 1'b0, w);
    send(1'b0, 32'h14, 4'h0, 32'h0, 8'h62, 1'b0, w);
    send(1'b0, 32'h20, 4'h0, 32'h0, 8'h63, 1'b0, w);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, busy, bus.req_ready} !== 3'b000)
        $display("FAIL midreset_outputs: valid/busy/ready=%b, required 000", {bus.rsp_valid, busy, bus.req_ready});
      else passes++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: busy=%b after reset, required 0", busy);
    else passes++;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL midreset_dropped: %0d responses after reset, required 0", seen);
    else passes++;
    @(posedge clk); #1;
    send(1'b0, 32'h10, 4'h0, 32'h0, 8'h70, 1'b1, w);
    send(1'b0, 32'h20, 4'h0, 32'h0, 8'h71, 1'b1, w);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int w;
    bit done = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send(1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom, 8'h00, 1'b1, w);
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          logic [31:0] a;
          a = 32'h100 + 32'(4 * $urandom_range(0, 15));
          if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 7));
          if ($urandom_range(0, 2) == 0)
            send(1'b1, a, 4'($urandom_range(0, 15)), $urandom, 8'h00, 1'b1, w);
          else
            send(1'b0, a, 4'h0, 32'h0, 8'($urandom_range(0, 255)), 1'b1, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_rw     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_byteen = 4'h0;
    bus.req_data   = 32'h0;
    bus.req_tag    = 8'h0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_write_read();
    test_byteen();
    test_throughput();
    test_backpressure();
    test_errors();
    test_reset_midflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
